// File: rtl/instr_fetch_if.sv
// Instruction fetch bus: fetch address/instruction to memory plus fetch/decode pipeline outputs.
// Optional FETCH_STATS_EN adds stall_cycles and flush_count.
interface instr_fetch_if;
   logic [31:0] currPC;
   logic [31:0] instr;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        halted;
   logic        fault;
   logic [31:0] number_instructions;
`ifdef FETCH_STATS_EN
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;
`endif

`ifdef FETCH_STATS_EN
   modport master (
      output currPC, if_valid, if_instr, if_pc, if_pc_plus4, halted, fault,
             number_instructions, stall_cycles, flush_count,
      input  instr, stall, redirect_valid, redirect_pc
   );
   modport slave (
      input  currPC, if_valid, if_instr, if_pc, if_pc_plus4, halted, fault,
             number_instructions, stall_cycles, flush_count,
      output instr, stall, redirect_valid, redirect_pc
   );
`else
   modport master (
      output currPC, if_valid, if_instr, if_pc, if_pc_plus4, halted, fault,
             number_instructions,
      input  instr, stall, redirect_valid, redirect_pc
   );
   modport slave (
      input  currPC, if_valid, if_instr, if_pc, if_pc_plus4, halted, fault,
             number_instructions,
      output instr, stall, redirect_valid, redirect_pc
   );
`endif
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, captures memory words into the fetch/decode register, handles
// stall, redirect, syscall halt and address faults. FETCH_STATS_EN adds stall/flush counters.
module instr_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0040_0000,
   parameter logic [31:0] PC_LAST    = 32'h0040_0400,
   parameter logic [31:0] HALT_INSTR = 32'h0000_000C
) (
   input  logic          clk,
   input  logic          rst,
   instr_fetch_if.master bus
);
   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT, S_FAULT} state_t;

   state_t            state_q, state_n;
   logic [XLEN-1:0]   pc_q, pc_n;
   logic [XLEN-1:0]   instr_q, instr_n;
   logic [XLEN-1:0]   ifpc_q, ifpc_n;
   logic [XLEN-1:0]   plus4_q, plus4_n;
   logic [XLEN-1:0]   cnt_q, cnt_n;
   logic              valid_q, valid_n;
   logic              halted_q, halted_n;
   logic              fault_q, fault_n;
`ifdef FETCH_STATS_EN
   logic [XLEN-1:0]   stall_cnt_q, stall_cnt_n;
   logic [XLEN-1:0]   flush_cnt_q, flush_cnt_n;
`endif

   // State and pipeline registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_BOOT;
         pc_q     <= RESET_PC;
         instr_q  <= '0;
         ifpc_q   <= '0;
         plus4_q  <= XLEN'(4);
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
`ifdef FETCH_STATS_EN
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
`endif
      end else begin
         state_q  <= state_n;
         pc_q     <= pc_n;
         instr_q  <= instr_n;
         ifpc_q   <= ifpc_n;
         plus4_q  <= plus4_n;
         cnt_q    <= cnt_n;
         valid_q  <= valid_n;
         halted_q <= halted_n;
         fault_q  <= fault_n;
`ifdef FETCH_STATS_EN
         stall_cnt_q <= stall_cnt_n;
         flush_cnt_q <= flush_cnt_n;
`endif
      end
   end

   // Next-state: redirect beats stall, stall beats range check, range check beats capture
   always_comb begin
      state_n = state_q;
      pc_n    = pc_q;
      instr_n = instr_q;
      ifpc_n  = ifpc_q;
      plus4_n = plus4_q;
      cnt_n   = cnt_q;
      valid_n = valid_q;
`ifdef FETCH_STATS_EN
      stall_cnt_n = stall_cnt_q;
      flush_cnt_n = flush_cnt_q;
`endif
      unique case (state_q)
         S_BOOT: begin
            state_n = S_RUN;
            valid_n = 1'b0;
         end
         S_RUN: begin
            if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)) begin
               state_n = S_FAULT;
               valid_n = 1'b0;
            end else if (bus.redirect_valid) begin
               pc_n    = bus.redirect_pc;
               valid_n = 1'b0;
`ifdef FETCH_STATS_EN
               flush_cnt_n = flush_cnt_q + XLEN'(1);
`endif
            end else if (bus.stall) begin
`ifdef FETCH_STATS_EN
               stall_cnt_n = stall_cnt_q + XLEN'(1);
`endif
            end else if (pc_q > PC_LAST) begin
               state_n = S_FAULT;
               valid_n = 1'b0;
            end else begin
               instr_n = bus.instr;
               ifpc_n  = pc_q;
               plus4_n = pc_q + XLEN'(4);
               valid_n = 1'b1;
               cnt_n   = cnt_q + XLEN'(1);
               // Halt word is delivered like any other, but the PC stops on it
               if (bus.instr == HALT_INSTR) state_n = S_HALT;
               else                         pc_n    = pc_q + XLEN'(4);
            end
         end
         S_HALT: begin
            if (!bus.stall) valid_n = 1'b0;
         end
         S_FAULT: begin
            valid_n = 1'b0;
         end
         default: begin
            state_n = S_FAULT;
            valid_n = 1'b0;
         end
      endcase
      halted_n = (state_n == S_HALT);
      fault_n  = (state_n == S_FAULT);
   end

   assign bus.currPC              = pc_q;
   assign bus.if_valid            = valid_q;
   assign bus.if_instr            = instr_q;
   assign bus.if_pc               = ifpc_q;
   assign bus.if_pc_plus4         = plus4_q;
   assign bus.halted              = halted_q;
   assign bus.fault               = fault_q;
   assign bus.number_instructions = cnt_q;
`ifdef FETCH_STATS_EN
   assign bus.stall_cycles        = stall_cnt_q;
   assign bus.flush_count         = flush_cnt_q;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: vector table through a scoreboard queue plus
// hand-written halt, fault, range and async-reset sequences. Honours FETCH_STATS_EN.
module tb_instr_fetch;
   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;

   instr_fetch_if bus ();

   instr_fetch dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      case (a)
         32'h0040_0000: return 32'h2008_0005;
         32'h0040_0004: return 32'h2009_0003;
         32'h0040_0008: return 32'h0109_5020;
         32'h0040_000C: return 32'h0000_000C;
         32'h0040_0040: return 32'h2010_0001;
         32'h0040_0044: return 32'h2011_0002;
         default:       return 32'h0000_0000;
      endcase
   endfunction

   assign bus.instr = mem_rd(bus.currPC);

   typedef struct {
      logic        stall;
      logic        rv;
      logic [31:0] rpc;
      logic [31:0] pc;
      logic        v;
      logic [31:0] ins;
      logic [31:0] ipc;
      logic [31:0] cnt;
   } vec_t;

   localparam int NV = 11;
   vec_t vecs [NV];
   vec_t sb [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic cycle(input logic s, input logic rv, input logic [31:0] rpc);
      bus.stall          = s;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      @(posedge clk);
      #1;
      bus.stall          = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      vec_t e;
      n_pass  = 0;
      n_total = 0;
      rst = 1'b1;
      bus.stall = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0;

      //          stall rv  rpc            currPC         v   if_instr       if_pc          count
      vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h0040_0000, 1'b0, 32'h0,        32'h0,        32'd0};
      vecs[1]  = '{1'b0, 1'b0, 32'h0,        32'h0040_0004, 1'b1, 32'h2008_0005, 32'h0040_0000, 32'd1};
      vecs[2]  = '{1'b0, 1'b0, 32'h0,        32'h0040_0008, 1'b1, 32'h2009_0003, 32'h0040_0004, 32'd2};
      vecs[3]  = '{1'b1, 1'b0, 32'h0,        32'h0040_0008, 1'b1, 32'h2009_0003, 32'h0040_0004, 32'd2};
      vecs[4]  = '{1'b1, 1'b0, 32'h0,        32'h0040_0008, 1'b1, 32'h2009_0003, 32'h0040_0004, 32'd2};
      vecs[5]  = '{1'b1, 1'b0, 32'h0,        32'h0040_0008, 1'b1, 32'h2009_0003, 32'h0040_0004, 32'd2};
      vecs[6]  = '{1'b0, 1'b0, 32'h0,        32'h0040_000C, 1'b1, 32'h0109_5020, 32'h0040_0008, 32'd3};
      vecs[7]  = '{1'b1, 1'b1, 32'h0040_0040, 32'h0040_0040, 1'b0, 32'h0109_5020, 32'h0040_0008, 32'd3};
      vecs[8]  = '{1'b0, 1'b0, 32'h0,        32'h0040_0044, 1'b1, 32'h2010_0001, 32'h0040_0040, 32'd4};
      vecs[9]  = '{1'b0, 1'b0, 32'h0,        32'h0040_0048, 1'b1, 32'h2011_0002, 32'h0040_0044, 32'd5};
      vecs[10] = '{1'b1, 1'b0, 32'h0,        32'h0040_0048, 1'b1, 32'h2011_0002, 32'h0040_0044, 32'd5};

      #12;
      chk("rst_currPC", bus.currPC, 32'h0040_0000);
      chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
      chk("rst_if_instr", bus.if_instr, 32'h0);
      chk("rst_if_pc", bus.if_pc, 32'h0);
      chk("rst_if_pc_plus4", bus.if_pc_plus4, 32'd4);
      chk("rst_halted", 32'(bus.halted), 32'd0);
      chk("rst_fault", 32'(bus.fault), 32'd0);
      chk("rst_count", bus.number_instructions, 32'd0);
`ifdef FETCH_STATS_EN
      chk("rst_stall_cycles", bus.stall_cycles, 32'd0);
      chk("rst_flush_count", bus.flush_count, 32'd0);
`endif
      rst = 1'b0;

      // Table: boot, fetch, stall, redirect-with-stall, resume
      for (int i = 0; i < NV; i++) begin
         sb.push_back(vecs[i]);
         cycle(vecs[i].stall, vecs[i].rv, vecs[i].rpc);
         e = sb.pop_front();
         chk($sformatf("v%0d_currPC", i), bus.currPC, e.pc);
         chk($sformatf("v%0d_if_valid", i), 32'(bus.if_valid), 32'(e.v));
         chk($sformatf("v%0d_if_instr", i), bus.if_instr, e.ins);
         chk($sformatf("v%0d_if_pc", i), bus.if_pc, e.ipc);
         chk($sformatf("v%0d_if_pc_plus4", i), bus.if_pc_plus4, e.ipc + 32'd4);
         chk($sformatf("v%0d_count", i), bus.number_instructions, e.cnt);
         chk($sformatf("v%0d_halted", i), 32'(bus.halted), 32'd0);
         chk($sformatf("v%0d_fault", i), 32'(bus.fault), 32'd0);
`ifdef FETCH_STATS_EN
         if (i == 5) chk("stall_cycles_after_3", bus.stall_cycles, 32'd3);
`endif
      end
`ifdef FETCH_STATS_EN
      chk("stall_cycles_end", bus.stall_cycles, 32'd4);
      chk("flush_count_end", bus.flush_count, 32'd1);
`endif

      // Halt on syscall word at 0x0040_000C
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);
      chk("pre_halt_currPC", bus.currPC, 32'h0040_000C);
      cycle(1'b0, 1'b0, 32'h0);
      chk("halt_if_valid", 32'(bus.if_valid), 32'd1);
      chk("halt_if_instr", bus.if_instr, 32'h0000_000C);
      chk("halt_if_pc", bus.if_pc, 32'h0040_000C);
      chk("halt_count", bus.number_instructions, 32'd4);
      chk("halt_currPC", bus.currPC, 32'h0040_000C);
      chk("halt_halted", 32'(bus.halted), 32'd1);
      cycle(1'b1, 1'b0, 32'h0);
      chk("halt_stall_valid_held", 32'(bus.if_valid), 32'd1);
      cycle(1'b0, 1'b0, 32'h0);
      chk("halt_valid_drop", 32'(bus.if_valid), 32'd0);
      cycle(1'b0, 1'b1, 32'h0040_0040);
      chk("halt_redirect_ignored", bus.currPC, 32'h0040_000C);
      chk("halt_still_halted", 32'(bus.halted), 32'd1);
      chk("halt_count_frozen", bus.number_instructions, 32'd4);
`ifdef FETCH_STATS_EN
      chk("halt_flush_count", bus.flush_count, 32'd0);
`endif

      // Misaligned redirect
      do_reset();
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 32'h0040_0042);
      chk("mis_fault", 32'(bus.fault), 32'd1);
      chk("mis_if_valid", 32'(bus.if_valid), 32'd0);
      chk("mis_currPC", bus.currPC, 32'h0040_0004);
      cycle(1'b0, 1'b1, 32'h0040_0040);
      cycle(1'b0, 1'b0, 32'h0);
      chk("mis_frozen_currPC", bus.currPC, 32'h0040_0004);
      chk("mis_frozen_count", bus.number_instructions, 32'd1);
      chk("mis_frozen_fault", 32'(bus.fault), 32'd1);

      // Sequential fetch past PC_LAST
      do_reset();
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b1, 32'h0040_03F0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0);
      chk("range_last_if_pc", bus.if_pc, 32'h0040_0400);
      chk("range_currPC", bus.currPC, 32'h0040_0404);
      chk("range_no_fault_yet", 32'(bus.fault), 32'd0);
      cycle(1'b0, 1'b0, 32'h0);
      chk("range_fault", 32'(bus.fault), 32'd1);
      chk("range_if_valid", 32'(bus.if_valid), 32'd0);
      chk("range_count", bus.number_instructions, 32'd5);

      // Asynchronous reset while stalled
      do_reset();
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 32'h0);
      bus.stall = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_currPC", bus.currPC, 32'h0040_0000);
      chk("arst_if_valid", 32'(bus.if_valid), 32'd0);
      chk("arst_count", bus.number_instructions, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.stall = 1'b0;
      cycle(1'b0, 1'b0, 32'h0);
      chk("arst_boot_valid", 32'(bus.if_valid), 32'd0);
      chk("arst_boot_currPC", bus.currPC, 32'h0040_0000);
      cycle(1'b0, 1'b0, 32'h0);
      chk("arst_first_if_pc", bus.if_pc, 32'h0040_0000);
      chk("arst_first_if_instr", bus.if_instr, 32'h2008_0005);
      chk("arst_first_count", bus.number_instructions, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
